// File: rtl/proc_pkg.sv
// Definitions shared between the 16-bit multicycle core and its instruction fetch sequencer.
package proc_pkg;

   localparam int unsigned DATA_W = 16;
   localparam logic [DATA_W-1:0] HALT_WORD_DEF = 16'hFFFF;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_LATCH = 3'd2;
   localparam logic [2:0] ST_ISSUE = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;
   localparam logic [2:0] ST_HALT  = 3'd5;
   localparam logic [2:0] ST_ERR   = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_ADDR  = ST_ADDR,
      S_LATCH = ST_LATCH,
      S_ISSUE = ST_ISSUE,
      S_WAIT  = ST_WAIT,
      S_HALT  = ST_HALT,
      S_ERR   = ST_ERR
   } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Saturating cycle counter with synchronous clear; flags expiry once the count reaches TIMEOUT.
module fetch_watchdog #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_q;

   // Next count: clear wins, then increment up to the limit and hold there.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer: reads the instruction ROM, hands each word to the core with a one-cycle Run
// pulse, waits for Done and advances the PC. Supports a halt word, single-step and a Done watchdog.
module instr_fetch #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = proc_pkg::DATA_W,
   parameter logic [DATA_W-1:0] HALT_WORD = proc_pkg::HALT_WORD_DEF,
   parameter int unsigned TIMEOUT   = 15,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Go,
   input  logic              Step,
   output logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] MemQ,
   output logic [DATA_W-1:0] DIN,
   output logic              Run,
   input  logic              Done,
   output logic              Halted,
   output logic              Error,
   output logic [CNT_W-1:0]  InstrCount
);

   import proc_pkg::*;

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] din_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              run_q;
   logic              halted_q;
   logic              error_q;
   logic              go_q;
   logic              token_q;

   logic go_rise_s;
   logic permit_s;
   logic wd_clr_s;
   logic wd_en_s;
   logic wd_expired_s;

   assign go_rise_s = Go & ~go_q;
   assign permit_s  = Step ? (go_rise_s | token_q) : Go;
   assign wd_clr_s  = (state_q == S_ISSUE);
   assign wd_en_s   = (state_q == S_WAIT) & ~Done;

   fetch_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk_i    (Clock),
      .rst_ni   (Resetn),
      .clr_i    (wd_clr_s),
      .en_i     (wd_en_s),
      .expired_o(wd_expired_s)
   );

   // Fetch FSM with PC, instruction register, counters and all outputs registered.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         din_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
         go_q     <= 1'b0;
         token_q  <= 1'b0;
      end else begin
         go_q  <= Go;
         run_q <= 1'b0;
         // A step request arriving while busy is remembered once and replayed at the next IDLE.
         if (Step && go_rise_s && (state_q != S_IDLE)) begin
            token_q <= 1'b1;
         end
         unique case (state_q)
            S_IDLE: begin
               if (permit_s) begin
                  state_q <= S_ADDR;
                  token_q <= 1'b0;
               end
            end
            S_ADDR: begin
               state_q <= S_LATCH;
            end
            S_LATCH: begin
               if (MemQ == HALT_WORD) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end else begin
                  din_q   <= MemQ;
                  run_q   <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (Done) begin
                  pc_q    <= pc_q + ADDR_W'(1);
                  state_q <= S_IDLE;
                  if (!(&cnt_q)) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end else if (wd_expired_s) begin
                  error_q <= 1'b1;
                  state_q <= S_ERR;
               end
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            S_ERR: begin
               state_q <= S_ERR;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ADDR       = pc_q;
   assign DIN        = din_q;
   assign Run        = run_q;
   assign Halted     = halted_q;
   assign Error      = error_q;
   assign InstrCount = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: ROM and core models, Run-time scoreboard, per-feature tasks.
module tb_instr_fetch;

   localparam int TIMEOUT = 15;

   typedef struct packed {
      logic [4:0]  addr;
      logic [15:0] din;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, go, step, spur, auto_done, go2, step2;
   int          done_delay;
   logic [4:0]  addr;
   logic [15:0] memq, din, icount;
   logic        run, done, halted, error;
   logic [1:0]  addr2;
   logic [15:0] memq2, din2, icount2;
   logic        run2, done2, halted2, error2;

   logic [15:0] rom1 [0:31];
   logic [15:0] rom2 [0:3];
   int          dcnt, dcnt2;
   exp_t        q1[$];
   exp_t        q2[$];
   int          vectors = 0, miscompares = 0, runs1 = 0, runs2 = 0;

   instr_fetch #(.ADDR_W(5), .TIMEOUT(TIMEOUT)) dut (
      .Clock(clk), .Resetn(rst_n), .Go(go), .Step(step), .ADDR(addr), .MemQ(memq),
      .DIN(din), .Run(run), .Done(done), .Halted(halted), .Error(error), .InstrCount(icount)
   );

   instr_fetch #(.ADDR_W(2), .TIMEOUT(TIMEOUT)) dut2 (
      .Clock(clk), .Resetn(rst_n), .Go(go2), .Step(step2), .ADDR(addr2), .MemQ(memq2),
      .DIN(din2), .Run(run2), .Done(done2), .Halted(halted2), .Error(error2), .InstrCount(icount2)
   );

   // Synchronous ROMs: data valid one cycle after the address.
   always @(posedge clk) begin
      memq  <= rom1[addr];
      memq2 <= rom2[addr2];
   end

   // Core models: Done pulses done_delay cycles after the cycle in which Run was seen.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt  <= 0;
         dcnt2 <= 0;
      end else begin
         if (run && auto_done) dcnt <= done_delay;
         else if (dcnt != 0) dcnt <= dcnt - 1;
         if (run2) dcnt2 <= 1;
         else if (dcnt2 != 0) dcnt2 <= dcnt2 - 1;
      end
   end
   assign done  = (dcnt == 1) | spur;
   assign done2 = (dcnt2 == 1);

   // Scoreboard for each DUT: every Run pops the expected address and instruction word.
   always @(negedge clk) begin
      if (run === 1'b1) begin
         exp_t e;
         runs1++;
         vectors++;
         if (q1.size() == 0) begin
            miscompares++;
            $display("FAIL run1_unexpected: got addr=%0d din=%h, expected no Run", addr, din);
         end else begin
            e = q1.pop_front();
            if (addr !== e.addr || din !== e.din) begin
               miscompares++;
               $display("FAIL run1_word: got addr=%0d din=%h, expected addr=%0d din=%h", addr, din, e.addr, e.din);
            end
         end
      end
      if (run2 === 1'b1) begin
         exp_t e2;
         runs2++;
         vectors++;
         if (q2.size() == 0) begin
            miscompares++;
            $display("FAIL run2_unexpected: got addr=%0d din=%h, expected no Run", addr2, din2);
         end else begin
            e2 = q2.pop_front();
            if ({3'b000, addr2} !== e2.addr || din2 !== e2.din) begin
               miscompares++;
               $display("FAIL run2_word: got addr=%0d din=%h, expected addr=%0d din=%h", addr2, din2, e2.addr, e2.din);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; go = 1'b0; go2 = 1'b0; step = 1'b0; spur = 1'b0;
      for (int i = 0; i < 32; i++) rom1[i] = 16'h0000;
      q1.delete();
      q2.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      runs1 = 0;
      runs2 = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++; if (addr !== 5'd0)      begin miscompares++; $display("FAIL reset_addr: got %0d, expected 0", addr); end
      vectors++; if (din !== 16'h0000)   begin miscompares++; $display("FAIL reset_din: got %h, expected 0000", din); end
      vectors++; if (run !== 1'b0)       begin miscompares++; $display("FAIL reset_run: got %b, expected 0", run); end
      vectors++; if (halted !== 1'b0)    begin miscompares++; $display("FAIL reset_halted: got %b, expected 0", halted); end
      vectors++; if (error !== 1'b0)     begin miscompares++; $display("FAIL reset_error: got %b, expected 0", error); end
      vectors++; if (icount !== 16'd0)   begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", icount); end
      vectors++; if (addr2 !== 2'd0)     begin miscompares++; $display("FAIL reset_addr2: got %0d, expected 0", addr2); end
      do_reset();
   endtask

   task automatic test_halt();
      do_reset();
      auto_done = 1'b1; done_delay = 1;
      rom1[0] = 16'h1005; rom1[1] = 16'hFFFF;
      q1.push_back({5'd0, 16'h1005});
      go = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (run !== 1'b1) begin miscompares++; $display("FAIL halt_latency: Run got %b, expected 1 three cycles after Go", run); end
      for (int k = 0; k < 40 && halted !== 1'b1; k++) @(negedge clk);
      vectors++; if (halted !== 1'b1)  begin miscompares++; $display("FAIL halt_flag: got %b, expected 1", halted); end
      vectors++; if (addr !== 5'd1)    begin miscompares++; $display("FAIL halt_addr: got %0d, expected 1", addr); end
      vectors++; if (icount !== 16'd1) begin miscompares++; $display("FAIL halt_count: got %0d, expected 1", icount); end
      vectors++; if (din !== 16'h1005) begin miscompares++; $display("FAIL halt_din: got %h, expected 1005", din); end
      repeat (10) @(negedge clk);
      vectors++; if (runs1 !== 1) begin miscompares++; $display("FAIL halt_runs: got %0d, expected 1", runs1); end
      go = 1'b0;
   endtask

   task automatic test_step();
      do_reset();
      step = 1'b1; auto_done = 1'b1; done_delay = 8;
      rom1[0] = 16'h2001; rom1[1] = 16'h2002; rom1[2] = 16'h2003; rom1[3] = 16'h2004;
      q1.push_back({5'd0, 16'h2001});
      go = 1'b1;
      for (int k = 0; k < 20 && run !== 1'b1; k++) @(negedge clk);
      @(negedge clk); go = 1'b0;
      @(negedge clk); go = 1'b1;
      q1.push_back({5'd1, 16'h2002});
      @(negedge clk); go = 1'b0;
      @(negedge clk); go = 1'b1;
      repeat (40) @(negedge clk);
      vectors++; if (runs1 !== 2)      begin miscompares++; $display("FAIL step_token_runs: got %0d, expected 2", runs1); end
      vectors++; if (icount !== 16'd2) begin miscompares++; $display("FAIL step_token_count: got %0d, expected 2", icount); end
      vectors++; if (addr !== 5'd2)    begin miscompares++; $display("FAIL step_token_addr: got %0d, expected 2", addr); end
      go = 1'b0;
      @(negedge clk); go = 1'b1;
      q1.push_back({5'd2, 16'h2003});
      repeat (30) @(negedge clk);
      vectors++; if (runs1 !== 3)      begin miscompares++; $display("FAIL step_edge_runs: got %0d, expected 3", runs1); end
      vectors++; if (icount !== 16'd3) begin miscompares++; $display("FAIL step_edge_count: got %0d, expected 3", icount); end
      vectors++; if (q1.size() !== 0)  begin miscompares++; $display("FAIL step_pending: got %0d, expected 0", q1.size()); end
      go = 1'b0; step = 1'b0;
   endtask

   task automatic test_watchdog();
      int cnt;
      do_reset();
      auto_done = 1'b0;
      rom1[0] = 16'h3001;
      q1.push_back({5'd0, 16'h3001});
      go = 1'b1;
      for (int k = 0; k < 20 && run !== 1'b1; k++) @(negedge clk);
      cnt = 0;
      for (int k = 0; k < 60 && error !== 1'b1; k++) begin
         @(negedge clk);
         if (error !== 1'b1) cnt++;
      end
      vectors++; if (cnt !== TIMEOUT + 1) begin miscompares++; $display("FAIL wd_cycles: got %0d, expected %0d", cnt, TIMEOUT + 1); end
      vectors++; if (error !== 1'b1)      begin miscompares++; $display("FAIL wd_error: got %b, expected 1", error); end
      auto_done = 1'b1; spur = 1'b1;
      repeat (10) @(negedge clk);
      spur = 1'b0;
      vectors++; if (runs1 !== 1)      begin miscompares++; $display("FAIL wd_runs: got %0d, expected 1", runs1); end
      vectors++; if (icount !== 16'd0) begin miscompares++; $display("FAIL wd_count: got %0d, expected 0", icount); end
      vectors++; if (addr !== 5'd0)    begin miscompares++; $display("FAIL wd_addr: got %0d, expected 0", addr); end
      go = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      rom2[0] = 16'h4000; rom2[1] = 16'h4001; rom2[2] = 16'h4002; rom2[3] = 16'h4003;
      for (int i = 0; i < 6; i++) q2.push_back({5'(i % 4), rom2[i % 4]});
      go2 = 1'b1;
      for (int k = 0; k < 200 && icount2 < 16'd6; k++) @(negedge clk);
      go2 = 1'b0;
      repeat (10) @(negedge clk);
      vectors++; if (icount2 !== 16'd6) begin miscompares++; $display("FAIL wrap_count: got %0d, expected 6", icount2); end
      vectors++; if (addr2 !== 2'd2)    begin miscompares++; $display("FAIL wrap_addr: got %0d, expected 2", addr2); end
      vectors++; if (runs2 !== 6)       begin miscompares++; $display("FAIL wrap_runs: got %0d, expected 6", runs2); end
      vectors++; if ({halted2, error2} !== 2'b00) begin miscompares++; $display("FAIL wrap_flags: got %b, expected 00", {halted2, error2}); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      auto_done = 1'b1; done_delay = 1;
      rom1[0] = 16'h5000; rom1[1] = 16'h5001; rom1[2] = 16'h5002; rom1[3] = 16'h5003;
      q1.push_back({5'd0, 16'h5000});
      q1.push_back({5'd1, 16'h5001});
      q1.push_back({5'd2, 16'h5002});
      go = 1'b1;
      for (int k = 0; k < 60 && icount < 16'd2; k++) @(negedge clk);
      auto_done = 1'b0;
      for (int k = 0; k < 20 && run !== 1'b1; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      vectors++; if (addr !== 5'd2)    begin miscompares++; $display("FAIL mid_addr_before: got %0d, expected 2", addr); end
      vectors++; if (din !== 16'h5002) begin miscompares++; $display("FAIL mid_din_before: got %h, expected 5002", din); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if ({addr, din, run, halted, error, icount} !== 40'd0) begin
         miscompares++;
         $display("FAIL mid_async: got addr=%0d din=%h run=%b halted=%b error=%b count=%0d, expected all 0", addr, din, run, halted, error, icount);
      end
      q1.push_back({5'd0, 16'h5000});
      auto_done = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); go = 1'b0;
      for (int k = 0; k < 30 && icount < 16'd1; k++) @(negedge clk);
      repeat (5) @(negedge clk);
      vectors++; if (icount !== 16'd1) begin miscompares++; $display("FAIL mid_count_after: got %0d, expected 1", icount); end
      vectors++; if (runs1 !== 4)      begin miscompares++; $display("FAIL mid_runs: got %0d, expected 4", runs1); end
   endtask

   task automatic test_spurious();
      do_reset();
      auto_done = 1'b1; done_delay = 1;
      rom1[0] = 16'h6000; rom1[1] = 16'h6001;
      spur = 1'b1;
      repeat (2) @(negedge clk);
      spur = 1'b0;
      vectors++; if ({addr, icount} !== 21'd0) begin miscompares++; $display("FAIL spur_idle: got addr=%0d count=%0d, expected 0 0", addr, icount); end
      q1.push_back({5'd0, 16'h6000});
      go = 1'b1; spur = 1'b1;
      @(negedge clk); go = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (run !== 1'b1) begin miscompares++; $display("FAIL spur_run: got %b, expected 1", run); end
      @(negedge clk); spur = 1'b0;
      vectors++; if ({addr, icount} !== 21'd0) begin miscompares++; $display("FAIL spur_issue: got addr=%0d count=%0d, expected 0 0", addr, icount); end
      @(negedge clk);
      vectors++; if (icount !== 16'd1 || addr !== 5'd1) begin miscompares++; $display("FAIL spur_wait: got addr=%0d count=%0d, expected 1 1", addr, icount); end
      spur = 1'b1;
      repeat (3) @(negedge clk);
      spur = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (icount !== 16'd1 || addr !== 5'd1 || runs1 !== 1) begin
         miscompares++;
         $display("FAIL spur_after: got addr=%0d count=%0d runs=%0d, expected 1 1 1", addr, icount, runs1);
      end
   endtask

   initial begin
      rst_n = 1'b0; go = 1'b0; go2 = 1'b0; step = 1'b0; step2 = 1'b0; spur = 1'b0;
      auto_done = 1'b1; done_delay = 1;
      for (int i = 0; i < 32; i++) rom1[i] = 16'h0000;
      for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_halt();
      test_step();
      test_watchdog();
      test_wrap();
      test_reset_mid();
      test_spurious();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
